// File: rtl/gray_event_timestamper.sv
// Event timestamp FIFO: captures the Gray count per channel event, stores Gray words,
// and decodes only the head entry to binary for readout under valid/ready.
module gray_event_timestamper #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CH_W   = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                gray_count,
  input  logic                       ev_valid,
  input  logic [CH_W-1:0]            ev_ch,
  input  logic                       rd_ready,
  input  logic                       clr_ovf,
  output logic                       rd_valid,
  output logic [15:0]                rd_time,
  output logic [CH_W-1:0]            rd_ch,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       ovf,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 16 + CH_W;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic              push, pop, drop;
  logic [EW-1:0]     head;
  logic [15:0]       head_gray;

  // A full FIFO still accepts an event when the head is popped on the same edge.
  always_comb begin
    pop  = rd_valid_q & rd_ready;
    push = ev_valid & (~full_q | pop);
    drop = ev_valid & full_q & ~pop;
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    rd_valid_d = (level_d != '0);
    full_d     = (level_d == LW'(DEPTH));
  end

  // A drop on the same edge as a clear leaves exactly that one drop recorded.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = DROP_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end else if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= {gray_count, ev_ch};
    end
  end

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_gray = head[CH_W +: 16];
    for (int i = 0; i < 16; i++) begin
      rd_time[i] = ^(head_gray >> i);
    end
    rd_ch = head[CH_W-1:0];
  end

  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign full     = full_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_gray_event_timestamper.sv
// Directed bench for gray_event_timestamper: a vector table for the basic flow and
// timestamp wrap, then hand sequences for fill/drop, full-with-pop, saturation and reset.
module tb_gray_event_timestamper;

  logic        clk = 1'b0;
  logic        reset, ev_valid, rd_ready, clr_ovf;
  logic [15:0] gray_count;
  logic [3:0]  ev_ch, rd_ch;
  logic        rd_valid, full, ovf;
  logic [15:0] rd_time;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  gray_event_timestamper #(
    .DEPTH  (8),
    .CH_W   (4),
    .DROP_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_count (gray_count),
    .ev_valid   (ev_valid),
    .ev_ch      (ev_ch),
    .rd_ready   (rd_ready),
    .clr_ovf    (clr_ovf),
    .rd_valid   (rd_valid),
    .rd_time    (rd_time),
    .rd_ch      (rd_ch),
    .level      (level),
    .full       (full),
    .ovf        (ovf),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ev;
    logic [15:0] t;
    logic [3:0]  ch;
    logic        rdy;
    logic        clr;
    logic        exp_v;
    logic [15:0] exp_t;
    logic [3:0]  exp_ch;
    logic [3:0]  exp_lvl;
    logic        exp_full;
    logic        exp_ovf;
    logic [7:0]  exp_drop;
  } vec_t;

  function automatic logic [15:0] to_gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string nm, input logic v, input logic [3:0] lvl,
                            input logic f, input logic o, input logic [7:0] d);
    chk({nm, ".rd_valid"}, 32'(rd_valid), 32'(v));
    chk({nm, ".level"}, 32'(level), 32'(lvl));
    chk({nm, ".full"}, 32'(full), 32'(f));
    chk({nm, ".ovf"}, 32'(ovf), 32'(o));
    chk({nm, ".drop_cnt"}, 32'(drop_cnt), 32'(d));
  endtask

  task automatic chk_head(input string nm, input logic [15:0] t, input logic [3:0] ch);
    chk({nm, ".rd_time"}, 32'(rd_time), 32'(t));
    chk({nm, ".rd_ch"}, 32'(rd_ch), 32'(ch));
  endtask

  // Drive one edge's inputs away from posedge, then return 1 time unit after it.
  task automatic step(input logic rst, input logic ev, input logic [15:0] bin,
                      input logic [3:0] ch, input logic rdy, input logic clr);
    @(negedge clk);
    reset      = rst;
    ev_valid   = ev;
    gray_count = to_gray(bin);
    ev_ch      = ch;
    rd_ready   = rdy;
    clr_ovf    = clr;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    reset = 1'b1; ev_valid = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    gray_count = '0; ev_ch = '0;

    //        rst ev  t        ch  rdy clr  v  exp_t    ch  lvl f  o  drop
    tbl[0]  = '{1, 0, 16'h0000, 0, 0, 0,  0, 16'h0000, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 16'h1234, 3, 0, 0,  1, 16'h1234, 3, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 16'h0000, 0, 0, 0,  1, 16'h1234, 3, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 16'h0000, 0, 1, 0,  0, 16'h0000, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 16'hFFFD, 1, 1, 0,  1, 16'hFFFD, 1, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 16'hFFFE, 2, 1, 0,  1, 16'hFFFE, 2, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 16'hFFFF, 3, 1, 0,  1, 16'hFFFF, 3, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 16'h0000, 4, 1, 0,  1, 16'h0000, 4, 1, 0, 0, 0};
    tbl[8]  = '{0, 1, 16'h0001, 5, 1, 0,  1, 16'h0001, 5, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 16'h0000, 0, 1, 0,  0, 16'h0000, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 16'h0000, 0, 1, 0,  0, 16'h0000, 0, 0, 0, 0, 0};

    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst, tbl[i].ev, tbl[i].t, tbl[i].ch, tbl[i].rdy, tbl[i].clr);
      chk_status($sformatf("tbl%0d", i), tbl[i].exp_v, tbl[i].exp_lvl, tbl[i].exp_full,
                 tbl[i].exp_ovf, tbl[i].exp_drop);
      if (tbl[i].exp_v) chk_head($sformatf("tbl%0d", i), tbl[i].exp_t, tbl[i].exp_ch);
    end

    // Ten events into an 8-deep FIFO: last two dropped, first eight read back in order.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 16'(16'h0100 + i * 3), 4'(i), 0, 0);
      chk_status($sformatf("fill%0d", i), 1, 4'((i < 8) ? i + 1 : 8), (i >= 7),
                 (i >= 8), 8'((i >= 8) ? i - 7 : 0));
    end
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("drain%0d", k), 16'(16'h0100 + k * 3), 4'(k));
      step(0, 0, 0, 0, 1, 0);
    end
    chk_status("drained", 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1);
    chk_status("clr", 0, 0, 0, 0, 0);

    // Event on a full FIFO with a simultaneous pop is accepted and becomes the tail.
    for (int k = 0; k < 8; k++) step(0, 1, 16'(16'h0200 + k), 4'(k), 0, 0);
    chk_status("full8", 1, 8, 1, 0, 0);
    step(0, 1, 16'h02FF, 4'hF, 1, 0);
    chk_status("fullpop", 1, 8, 1, 0, 0);
    for (int k = 1; k < 9; k++) begin
      if (k < 8) chk_head($sformatf("fp%0d", k), 16'(16'h0200 + k), 4'(k));
      else       chk_head("fp_last", 16'h02FF, 4'hF);
      step(0, 0, 0, 0, 1, 0);
    end
    chk_status("fp_empty", 0, 0, 0, 0, 0);

    // Drop counter saturation, then clear and drop on the same edge.
    for (int k = 0; k < 8; k++) step(0, 1, 16'(16'h0400 + k), 4'(k), 0, 0);
    for (int k = 0; k < 255; k++) step(0, 1, 16'h0500, 0, 0, 0);
    chk_status("sat255", 1, 8, 1, 1, 255);
    for (int k = 0; k < 3; k++) step(0, 1, 16'h0501, 0, 0, 0);
    chk_status("sat_hold", 1, 8, 1, 1, 255);
    step(0, 1, 16'h0502, 0, 0, 1);
    chk_status("clr_drop", 1, 8, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    chk_status("clr_only", 1, 8, 1, 0, 0);
    chk_head("sat_head", 16'h0400, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, 0);
    chk_status("sat_empty", 0, 0, 0, 0, 0);

    // Reset mid-stream discards everything, including the event on the reset edge.
    for (int k = 0; k < 5; k++) step(0, 1, 16'(16'h0300 + k), 4'(k), 0, 0);
    chk_status("pre_rst", 1, 5, 0, 0, 0);
    step(1, 1, 16'h03AA, 4'h9, 0, 0);
    chk_status("rst_mid", 0, 0, 0, 0, 0);
    step(0, 1, 16'h03BB, 4'h7, 0, 0);
    chk_status("post_rst", 1, 1, 0, 0, 0);
    chk_head("post_rst", 16'h03BB, 4'h7);
    step(0, 0, 0, 0, 1, 0);
    chk_status("post_pop", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
